bus_write_sequencer: RTL

//   Memory-write side of the 65c02 external data bus. Internal registers
//   (accumulator, X/Y, P, PCH/PCL) hand it address+byte pairs; it runs the

---
 rtl/bus_write_sequencer.sv | 212 +++++++++++++++++++++
 1 files changed

// File: rtl/bus_write_sequencer.sv
// bus_write_sequencer
//   Memory-write side of the 65c02 external data bus. Write requests
//   (address + byte) are queued in a small FIFO. Each one is then run as an
//   external write cycle: address setup with RWB high, a strobe with RWB low
//   and data driven (stretched by RDY wait states), and an optional data hold.
//
// Ports
//   fclk        in   system clock, rising edge
//   rst         in   asynchronous active-high reset
//   req_valid   in   write request present
//   req_ready   out  FIFO can accept (registered, = !full)
//   req_addr    in   [15:0] write address
//   req_data    in   [7:0]  write byte
//   rdy         in   external ready, 0 = wait state during strobe
//   addr_out    out  [15:0] external address bus
//   data_out    out  [7:0]  external data bus
//   data_oe     out  data bus output enable
//   rwb         out  1 = read/idle, 0 = write strobe
//   write_done  out  one-cycle pulse after a strobe completes
//   busy        out  state != IDLE or FIFO non-empty
//   dbg_state   out  [1:0] FSM state (0 IDLE, 1 SETUP, 2 STROBE, 3 HOLD)
//
// Handshake: a request is taken on a rising edge where req_valid=1 and
//   req_ready=1. req_ready comes from a register, so a pop never raises it
//   within the same cycle; the requester may hold req_valid and its payload
//   until it sees the transfer.

module bus_write_sequencer #(
   parameter int DEPTH        = 2,
   parameter int SETUP_CYCLES = 1,
   parameter int HOLD_CYCLES  = 1
) (
   input  logic        fclk,
   input  logic        rst,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic [15:0] req_addr,
   input  logic [7:0]  req_data,
   input  logic        rdy,
   output logic [15:0] addr_out,
   output logic [7:0]  data_out,
   output logic        data_oe,
   output logic        rwb,
   output logic        write_done,
   output logic        busy,
   output logic [1:0]  dbg_state
);

   localparam int PW   = $clog2(DEPTH);
   localparam int MAXC = (SETUP_CYCLES > HOLD_CYCLES) ? SETUP_CYCLES : HOLD_CYCLES;
   localparam int CW   = $clog2(MAXC + 1);

   localparam logic [PW:0]   FULL_CNT   = (PW + 1)'(DEPTH);
   localparam logic [PW:0]   ONE_CNT    = (PW + 1)'(1);
   localparam logic [CW-1:0] SETUP_LOAD = CW'(SETUP_CYCLES - 1);
   localparam logic [CW-1:0] HOLD_LOAD  = CW'((HOLD_CYCLES > 0) ? HOLD_CYCLES - 1 : 0);

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_SETUP  = 2'd1,
      S_STROBE = 2'd2,
      S_HOLD   = 2'd3
   } state_t;

   // Request FIFO
   logic [15:0]   addr_mem_q [DEPTH];
   logic [7:0]    data_mem_q [DEPTH];
   logic [PW-1:0] wr_ptr_q;
   logic [PW-1:0] rd_ptr_q;
   logic [PW-1:0] rd_next;
   logic [PW:0]   count_q;
   logic [PW:0]   count_d;
   logic          ready_q;
   logic          push;
   logic          pop;

   // Sequencer
   state_t        state_q;
   logic [CW-1:0] cnt_q;
   logic [15:0]   addr_q;
   logic [7:0]    data_q;
   logic          oe_q;
   logic          rwb_q;
   logic          done_q;
   logic          busy_q;

   assign push    = req_valid & ready_q;
   // The strobe completes on the edge where rdy is seen high in STROBE.
   assign pop     = (state_q == S_STROBE) & rdy;
   assign rd_next = rd_ptr_q + 1'b1;

   always_comb begin
      count_d = count_q;
      case ({push, pop})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge fclk or posedge rst) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         ready_q  <= 1'b1;
      end else begin
         if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
         if (pop)  rd_ptr_q <= rd_next;
         count_q <= count_d;
         ready_q <= (count_d != FULL_CNT);
      end
   end

   // Storage needs no reset: entries are only read behind a valid count.
   always_ff @(posedge fclk) begin
      if (push) begin
         addr_mem_q[wr_ptr_q] <= req_addr;
         data_mem_q[wr_ptr_q] <= req_data;
      end
   end

   always_ff @(posedge fclk or posedge rst) begin
      if (rst) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         addr_q  <= 16'h0000;
         data_q  <= 8'h00;
         oe_q    <= 1'b0;
         rwb_q   <= 1'b1;
         done_q  <= 1'b0;
         busy_q  <= 1'b0;
      end else begin
         done_q <= pop;
         case (state_q)
            S_IDLE: begin
               if (count_q != '0) begin
                  state_q <= S_SETUP;
                  cnt_q   <= SETUP_LOAD;
                  addr_q  <= addr_mem_q[rd_ptr_q];
                  data_q  <= data_mem_q[rd_ptr_q];
                  busy_q  <= 1'b1;
               end else begin
                  busy_q  <= (count_d != '0);
               end
            end
            S_SETUP: begin
               busy_q <= 1'b1;
               if (cnt_q == '0) begin
                  state_q <= S_STROBE;
                  rwb_q   <= 1'b0;
                  oe_q    <= 1'b1;
               end else begin
                  cnt_q   <= cnt_q - 1'b1;
               end
            end
            S_STROBE: begin
               busy_q <= 1'b1;
               if (rdy) begin
                  rwb_q <= 1'b1;
                  if (HOLD_CYCLES > 0) begin
                     state_q <= S_HOLD;
                     cnt_q   <= HOLD_LOAD;
                  end else begin
                     oe_q <= 1'b0;
                     // The head is being popped this edge, so the next
                     // request (if any) sits one slot further on. A request
                     // pushed on this same edge is picked up via IDLE.
                     if (count_q > ONE_CNT) begin
                        state_q <= S_SETUP;
                        cnt_q   <= SETUP_LOAD;
                        addr_q  <= addr_mem_q[rd_next];
                        data_q  <= data_mem_q[rd_next];
                     end else begin
                        state_q <= S_IDLE;
                        busy_q  <= (count_d != '0);
                     end
                  end
               end
            end
            S_HOLD: begin
               busy_q <= 1'b1;
               if (cnt_q == '0) begin
                  oe_q <= 1'b0;
                  if (count_q != '0) begin
                     state_q <= S_SETUP;
                     cnt_q   <= SETUP_LOAD;
                     addr_q  <= addr_mem_q[rd_ptr_q];
                     data_q  <= data_mem_q[rd_ptr_q];
                  end else begin
                     state_q <= S_IDLE;
                     busy_q  <= (count_d != '0);
                  end
               end else begin
                  cnt_q <= cnt_q - 1'b1;
               end
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign req_ready  = ready_q;
   assign addr_out   = addr_q;
   assign data_out   = data_q;
   assign data_oe    = oe_q;
   assign rwb        = rwb_q;
   assign write_done = done_q;
   assign busy       = busy_q;
   assign dbg_state  = state_q;

endmodule
